// File: rtl/i2c_master_engine.sv
// i2c_master_engine: byte-level I2C initiator with a valid/ready command port.
// Commands are START, STOP, WRITE and READ. SCL and SDA are open-drain enables,
// where 1 releases the line and 0 pulls it low.
// Each SCL period has four quarters of CLK_DIV clocks. Line changes are registered
// at the clock edge that starts a quarter.
// Optional build macro: I2C_MASTER_CLK_STRETCH_EN.
// When it is defined, the SCL-high quarter waits for the sensed SCL line to go high
// before it starts counting, so that a slave can stretch the clock.
module i2c_master_engine #(
   parameter int CLK_DIV        = 4,
   parameter int I2C_DATA_WIDTH = 8
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      cmd_valid_i,
   output logic                      cmd_ready_o,
   input  logic [1:0]                cmd_i,
   input  logic [I2C_DATA_WIDTH-1:0] wdata_i,
   input  logic                      rd_ack_i,
   output logic                      done_o,
   output logic [I2C_DATA_WIDTH-1:0] rdata_o,
   output logic                      nack_o,
   output logic                      busy_o,
   input  logic                      scl_i,
   input  logic                      sda_i,
   output logic                      scl_o,
   output logic                      sda_o
);

   localparam int QW = 10;
   localparam int BW = $clog2(I2C_DATA_WIDTH + 1);

   typedef enum logic [1:0] {IDLE, START_SEQ, STOP_SEQ, DATA} state_t;

   state_t                    state_q, state_d;
   logic [QW-1:0]             qcnt_q, qcnt_d;
   logic [1:0]                quarter_q, quarter_d;
   logic [BW-1:0]             bit_q, bit_d;
   logic                      is_rd_q, is_rd_d;
   logic                      rd_ack_q, rd_ack_d;
   logic                      samp_q, samp_d;
   logic [I2C_DATA_WIDTH-1:0] shreg_q, shreg_d;
   logic [I2C_DATA_WIDTH-1:0] rdata_d;
   logic                      scl_d, sda_d, busy_d, done_d, nack_d;
   logic                      q_last, sample_now, stretch_hold;

   assign cmd_ready_o = (state_q == IDLE);
   assign q_last      = (qcnt_q == QW'(CLK_DIV - 1));
   assign sample_now  = (state_q == DATA) && (quarter_q == 2'd2) && (qcnt_q == '0);

`ifdef I2C_MASTER_CLK_STRETCH_EN
   // The SCL-high quarter does not start counting until the wired line reads high.
   assign stretch_hold = (state_q != IDLE) && (quarter_q == 2'd1) && (qcnt_q == '0) && !scl_i;
`else
   logic unused_scl;
   assign unused_scl   = scl_i;
   assign stretch_hold = 1'b0;
`endif

   // Next-state and next-output decode for command sequencing
   always_comb begin
      state_d   = state_q;
      qcnt_d    = qcnt_q;
      quarter_d = quarter_q;
      bit_d     = bit_q;
      is_rd_d   = is_rd_q;
      rd_ack_d  = rd_ack_q;
      samp_d    = samp_q;
      shreg_d   = shreg_q;
      rdata_d   = rdata_o;
      scl_d     = scl_o;
      sda_d     = sda_o;
      busy_d    = busy_o;
      nack_d    = nack_o;
      done_d    = 1'b0;
      if (state_q == IDLE) begin
         if (cmd_valid_i) begin
            qcnt_d    = '0;
            quarter_d = 2'd0;
            bit_d     = '0;
            if (cmd_i == 2'b00) begin
               // Q0 of START raises SDA. For a repeated start, SCL is still low at this point.
               state_d = START_SEQ;
               sda_d   = 1'b1;
            end else if (!busy_o) begin
               // Without bus ownership the command is refused and the bus is left untouched.
               done_d = 1'b1;
               nack_d = 1'b1;
            end else if (cmd_i == 2'b01) begin
               state_d = STOP_SEQ;
               sda_d   = 1'b0;
            end else begin
               state_d  = DATA;
               is_rd_d  = cmd_i[0];
               rd_ack_d = rd_ack_i;
               shreg_d  = wdata_i;
               sda_d    = cmd_i[0] ? 1'b1 : wdata_i[I2C_DATA_WIDTH-1];
            end
         end
      end else begin
         if (!stretch_hold) begin
            if (!q_last) begin
               qcnt_d = qcnt_q + QW'(1);
            end else begin
               qcnt_d    = '0;
               quarter_d = quarter_q + 2'd1;
               case (quarter_q)
                  2'd0: scl_d = 1'b1;
                  2'd1: begin
                     if (state_q == START_SEQ) sda_d = 1'b0;
                     if (state_q == STOP_SEQ)  sda_d = 1'b1;
                  end
                  2'd2: if (state_q != STOP_SEQ) scl_d = 1'b0;
                  default: begin
                     if (state_q == DATA && bit_q != BW'(I2C_DATA_WIDTH)) begin
                        // Present the next bit while SCL is low.
                        // By now the shift register holds the next write bit at its MSB.
                        bit_d = bit_q + BW'(1);
                        if (bit_q == BW'(I2C_DATA_WIDTH - 1))
                           sda_d = is_rd_q ? ~rd_ack_q : 1'b1;
                        else
                           sda_d = is_rd_q ? 1'b1 : shreg_q[I2C_DATA_WIDTH-1];
                     end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        nack_d  = 1'b0;
                        if (state_q == START_SEQ) busy_d = 1'b1;
                        if (state_q == STOP_SEQ)  busy_d = 1'b0;
                        if (state_q == DATA) begin
                           nack_d = is_rd_q ? 1'b0 : samp_q;
                           if (is_rd_q) rdata_d = shreg_q;
                        end
                     end
                  end
               endcase
            end
         end
         if (sample_now) begin
            if (bit_q != BW'(I2C_DATA_WIDTH))
               shreg_d = {shreg_q[I2C_DATA_WIDTH-2:0], sda_i};
            else
               samp_d = sda_i;
         end
      end
   end

   // Control state and line drivers; an asynchronous reset releases both lines immediately
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q   <= IDLE;
         qcnt_q    <= '0;
         quarter_q <= 2'd0;
         bit_q     <= '0;
         is_rd_q   <= 1'b0;
         scl_o     <= 1'b1;
         sda_o     <= 1'b1;
         busy_o    <= 1'b0;
         done_o    <= 1'b0;
         nack_o    <= 1'b0;
         rdata_o   <= '0;
      end else begin
         state_q   <= state_d;
         qcnt_q    <= qcnt_d;
         quarter_q <= quarter_d;
         bit_q     <= bit_d;
         is_rd_q   <= is_rd_d;
         scl_o     <= scl_d;
         sda_o     <= sda_d;
         busy_o    <= busy_d;
         done_o    <= done_d;
         nack_o    <= nack_d;
         rdata_o   <= rdata_d;
      end
   end

   // Byte shift register and sampled ACK bits; always written before they are used
   always_ff @(posedge clk_i) begin
      shreg_q  <= shreg_d;
      rd_ack_q <= rd_ack_d;
      samp_q   <= samp_d;
   end

endmodule

// File: tb/tb_i2c_master_engine.sv
// tb_i2c_master_engine: randomized bench for i2c_master_engine.
// A behavioural slave shares the wired-AND bus with the master.
// A bus monitor decodes SCL-high bits and START/STOP conditions.
// The reference model predicts latency, ACK status, read data and bus ownership
// from the command-level rules.
module tb_i2c_master_engine;

   localparam int CLK_DIV = 4;
   localparam logic [1:0] C_START = 2'b00, C_STOP = 2'b01, C_WRITE = 2'b10, C_READ = 2'b11;

   logic       clk = 1'b0;
   logic       rst_i = 1'b1;
   logic       cmd_valid_i = 1'b0;
   logic [1:0] cmd_i = 2'b00;
   logic [7:0] wdata_i = 8'h00;
   logic       rd_ack_i = 1'b0;
   logic       cmd_ready_o, done_o, nack_o, busy_o, scl_o, sda_o, scl_i, sda_i;
   logic [7:0] rdata_o;

   // Slave and monitor state
   logic        slave_scl = 1'b1;
   logic        slave_sda;
   logic        armed = 1'b0;
   logic [8:0]  pat = 9'h1FF;
   int unsigned fall_cnt = 0;
   int unsigned arm_base = 0;
   int unsigned slave_off;
   int          stretch_len = 0;
   logic        mon_bits[$];
   int          start_cnt = 0, stop_cnt = 0;
   logic        scl_o_prev = 1'b1, scl_prev = 1'b1, sda_prev = 1'b1;

   // Reference model state
   logic        busy_m = 1'b0;
   logic [7:0]  rdata_m = 8'h00;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   i2c_master_engine #(.CLK_DIV(CLK_DIV), .I2C_DATA_WIDTH(8)) dut (
      .clk_i(clk), .rst_i(rst_i), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
      .cmd_i(cmd_i), .wdata_i(wdata_i), .rd_ack_i(rd_ack_i), .done_o(done_o),
      .rdata_o(rdata_o), .nack_o(nack_o), .busy_o(busy_o), .scl_i(scl_i), .sda_i(sda_i),
      .scl_o(scl_o), .sda_o(sda_o)
   );

   assign scl_i = scl_o & slave_scl;
   assign sda_i = sda_o & slave_sda;

   // Slave advances one bit per SCL falling edge after it is armed
   always @(negedge scl_o) fall_cnt <= fall_cnt + 1;

   always_comb begin
      slave_sda = 1'b1;
      slave_off = fall_cnt - arm_base;
      if (armed && slave_off <= 32'd8) slave_sda = pat[4'(32'd8 - slave_off)];
   end

   // Bus monitor: bits on SCL rise, START/STOP as SDA edges while SCL is high
   always @(negedge clk) begin
      if (scl_o && !scl_o_prev) mon_bits.push_back(sda_i);
      if (scl_i && scl_prev && sda_prev && !sda_i) start_cnt <= start_cnt + 1;
      if (scl_i && scl_prev && !sda_prev && sda_i) stop_cnt <= stop_cnt + 1;
      scl_o_prev <= scl_o;
      scl_prev   <= scl_i;
      sda_prev   <= sda_i;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue one command, then compare the outcome with the reference model
   task automatic do_cmd(input logic [1:0] cmd, input logic [7:0] wd, input logic rack,
                         input logic [7:0] sbyte, input logic sack);
      logic       legal, exp_nack;
      int         exp_lat, lat, st0, sp0, mb0;
      logic [8:0] bits, exp_bits;
      @(negedge clk);
      legal    = (cmd == C_START) || busy_m;
      exp_lat  = !legal ? 0 : (cmd[1] ? 36 * CLK_DIV : 4 * CLK_DIV);
`ifdef I2C_MASTER_CLK_STRETCH_EN
      if (legal && cmd[1]) exp_lat += stretch_len;
`endif
      exp_nack = !legal || (cmd == C_WRITE && sack);
      exp_bits = (cmd == C_READ) ? {sbyte, ~rack} : {wd, sack};
      if (legal && cmd == C_READ) rdata_m = sbyte;
      pat      = (cmd == C_READ) ? {sbyte, 1'b1} : {8'hFF, sack};
      arm_base = fall_cnt;
      armed    = legal && cmd[1];
      st0 = start_cnt; sp0 = stop_cnt; mb0 = mon_bits.size();
      check("ready_idle", 32'(cmd_ready_o), 32'd1);
      cmd_i = cmd; wdata_i = wd; rd_ack_i = rack; cmd_valid_i = 1'b1;
      if (armed && stretch_len > 0) begin
         fork
            begin
               for (int i = 0; i < 4000 && (fall_cnt - arm_base) < 5; i++) @(posedge clk);
               @(posedge scl_o);
               slave_scl = 1'b0;
               repeat (stretch_len) @(posedge clk);
               #1 slave_scl = 1'b1;
            end
         join_none
      end
      @(posedge clk); #1;
      cmd_valid_i = 1'b0; wdata_i = 8'($urandom); rd_ack_i = 1'($urandom);
      if (legal) check("ready_busy", 32'(cmd_ready_o), 32'd0);
      lat = 0;
      while (!done_o && lat < 4000) begin
         @(posedge clk); #1;
         lat++;
      end
      if (legal && cmd == C_START) busy_m = 1'b1;
      if (legal && cmd == C_STOP)  busy_m = 1'b0;
      check("latency", 32'(lat), 32'(exp_lat));
      check("nack", 32'(nack_o), 32'(exp_nack));
      check("rdata", 32'(rdata_o), 32'(rdata_m));
      check("busy", 32'(busy_o), 32'(busy_m));
      check("scl_end", 32'(scl_o), 32'(!busy_m));
      if (!busy_m) check("sda_end", 32'(sda_o), 32'd1);
      if (armed) begin
         check("nbits", 32'(mon_bits.size() - mb0), 32'd9);
         bits = '0;
         if (mon_bits.size() - mb0 >= 9)
            for (int k = 0; k < 9; k++) bits = {bits[7:0], mon_bits[mb0 + k]};
         check("bus_bits", 32'(bits), 32'(exp_bits));
      end else if (!legal) begin
         check("nbits_illegal", 32'(mon_bits.size() - mb0), 32'd0);
      end
      check("starts", 32'(start_cnt - st0), (legal && cmd == C_START) ? 32'd1 : 32'd0);
      check("stops", 32'(stop_cnt - sp0), (legal && cmd == C_STOP) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
      check("done_pulse", 32'(done_o), 32'd0);
      armed = 1'b0;
   endtask

   // Assert reset asynchronously while bit 3 of a WRITE is on the bus
   task automatic reset_mid_write();
      int         sp0, i;
      logic [7:0] wd;
      wd = 8'($urandom) & 8'hEF;
      @(negedge clk);
      check("ready_idle_r", 32'(cmd_ready_o), 32'd1);
      pat = 9'h1FE; arm_base = fall_cnt; armed = 1'b1; sp0 = stop_cnt;
      cmd_i = C_WRITE; wdata_i = wd; cmd_valid_i = 1'b1;
      @(posedge clk); #1;
      cmd_valid_i = 1'b0;
      i = 0;
      while ((fall_cnt - arm_base) < 3 && i < 2000) begin
         @(posedge clk); #1;
         i++;
      end
      repeat (CLK_DIV + 1) @(posedge clk);
      @(negedge clk); #1;
      check("pre_rst_scl", 32'(scl_o), 32'd0);
      check("pre_rst_sda", 32'(sda_o), 32'd0);
      rst_i = 1'b0;
      #1;
      check("rst_scl", 32'(scl_o), 32'd1);
      check("rst_sda", 32'(sda_o), 32'd1);
      check("rst_ready", 32'(cmd_ready_o), 32'd1);
      check("rst_busy", 32'(busy_o), 32'd0);
      @(negedge clk);
      rst_i = 1'b1;
      armed = 1'b0; busy_m = 1'b0; rdata_m = 8'h00;
      check("rst_no_stop", 32'(stop_cnt - sp0), 32'd0);
   endtask

   initial begin
      #2 rst_i = 1'b0;
      #1;
      check("reset_ready", 32'(cmd_ready_o), 32'd1);
      check("reset_done", 32'(done_o), 32'd0);
      check("reset_rdata", 32'(rdata_o), 32'd0);
      check("reset_nack", 32'(nack_o), 32'd0);
      check("reset_busy", 32'(busy_o), 32'd0);
      check("reset_scl", 32'(scl_o), 32'd1);
      check("reset_sda", 32'(sda_o), 32'd1);
      @(negedge clk);
      rst_i = 1'b1;
      repeat (2) @(posedge clk);

      // Write with ACK, write with NACK, then write followed by read
      do_cmd(C_START, 8'h00, 1'b0, 8'h00, 1'b0);
      do_cmd(C_WRITE, 8'h84, 1'b0, 8'h00, 1'b0);
      do_cmd(C_WRITE, 8'h84, 1'b0, 8'h00, 1'b1);
      do_cmd(C_WRITE, 8'h85, 1'b0, 8'h00, 1'b0);
      do_cmd(C_READ,  8'h00, 1'b0, 8'hA5, 1'b0);
      // Repeated start, acknowledged read, then stop
      do_cmd(C_START, 8'h00, 1'b0, 8'h00, 1'b0);
      do_cmd(C_READ,  8'h00, 1'b1, 8'h3C, 1'b0);
      do_cmd(C_STOP,  8'h00, 1'b0, 8'h00, 1'b0);
      // Commands issued without bus ownership
      do_cmd(C_WRITE, 8'h55, 1'b0, 8'h00, 1'b0);
      do_cmd(C_READ,  8'h00, 1'b1, 8'h77, 1'b0);
      do_cmd(C_STOP,  8'h00, 1'b0, 8'h00, 1'b0);
      // Reset in the middle of a write
      do_cmd(C_START, 8'h00, 1'b0, 8'h00, 1'b0);
      reset_mid_write();
      // Slave clock stretch at bit 5
      do_cmd(C_START, 8'h00, 1'b0, 8'h00, 1'b0);
      stretch_len = 20;
      do_cmd(C_WRITE, 8'($urandom), 1'b0, 8'h00, 1'b0);
      stretch_len = 0;
      do_cmd(C_WRITE, 8'($urandom), 1'b0, 8'h00, 1'b0);

      // Random command mix
      for (int n = 0; n < 40; n++) begin
         int r;
         logic [1:0] c;
         r = int'($urandom_range(0, 9));
         if (!busy_m) c = (r < 7) ? C_START : 2'(r - 6);
         else c = (r < 2) ? C_START : (r < 4) ? C_STOP : (r < 7) ? C_WRITE : C_READ;
         do_cmd(c, 8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
      end
      if (busy_m) do_cmd(C_STOP, 8'h00, 1'b0, 8'h00, 1'b0);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
